// File: rtl/mobilenet_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mobilenet_pkg
//  Brief    : Shared FSM encodings and constants for the MobileNet back end.
//  Revision : 1.0
// ============================================================================
package mobilenet_pkg;

    localparam int c_NUM_CLASSES_DEF = 1000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } state_e;

    // Most-negative two's-complement value of a given width, sign-extended to 64 bits.
    function automatic logic [63:0] neg_min(input int unsigned width);
        return {64{1'b1}} << (width - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/topk_slot.sv
`default_nettype none
// ============================================================================
//  Module   : topk_slot
//  Brief    : One entry of the sorted top-K table (valid, score, class index).
//  Revision : 1.0
// ============================================================================
module topk_slot
    import mobilenet_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_accept,
    input  logic              i_ins_here,
    input  logic              i_shift,
    input  logic              i_up_valid,
    input  logic [DATA_W-1:0] i_up_score,
    input  logic [IDX_W-1:0]  i_up_idx,
    input  logic [DATA_W-1:0] i_new_score,
    input  logic [IDX_W-1:0]  i_new_idx,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_score,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_beaten
);

    localparam logic [63:0]       c_NEG_FULL = neg_min(DATA_W);
    localparam logic [DATA_W-1:0] c_NEG      = c_NEG_FULL[DATA_W-1:0];

    logic              r_valid_q, w_valid_d;
    logic [DATA_W-1:0] r_score_q, w_score_d;
    logic [IDX_W-1:0]  r_idx_q,   w_idx_d;

    always_comb begin
        w_valid_d = r_valid_q;
        w_score_d = r_score_q;
        w_idx_d   = r_idx_q;
        if (i_clear) begin
            w_valid_d = 1'b0;
            w_score_d = c_NEG;
            w_idx_d   = '0;
        end else if (i_accept && i_ins_here) begin
            w_valid_d = 1'b1;
            w_score_d = i_new_score;
            w_idx_d   = i_new_idx;
        end else if (i_accept && i_shift) begin
            w_valid_d = i_up_valid;
            w_score_d = i_up_score;
            w_idx_d   = i_up_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_score_q <= c_NEG;
            r_idx_q   <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_score_q <= w_score_d;
            r_idx_q   <= w_idx_d;
        end
    end

    // Strictly greater: an equal later score never displaces an earlier class.
    assign o_beaten = !r_valid_q || ($signed(i_new_score) > $signed(r_score_q));
    assign o_valid  = r_valid_q;
    assign o_score  = r_score_q;
    assign o_idx    = r_idx_q;

endmodule
`default_nettype wire

// File: rtl/mobilenet_topk_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : mobilenet_topk_classifier
//  Brief    : Streams FC logits into a sorted top-K table, then emits K records.
//  Revision : 1.0
// ============================================================================
module mobilenet_topk_classifier
    import mobilenet_pkg::*;
#(
    parameter int NUM_CLASSES = c_NUM_CLASSES_DEF,
    parameter int DATA_W      = 32,
    parameter int K           = 5,
    parameter int IDX_W       = 10
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_rank,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_score,
    output logic              out_last,
    output logic              done,
    output logic              err_len,
    output logic [1:0]        fsm_state
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_e            r_state_q, w_state_d;
    logic [IDX_W-1:0]  r_cnt_q,   w_cnt_d;
    logic [2:0]        r_rank_q,  w_rank_d;
    logic              r_err_q,   w_err_d;
    logic              r_done_q,  w_done_d;

    logic              w_accept, w_clear, w_at_last, w_seen;
    logic [K-1:0]      w_valid, w_beaten, w_ins, w_shf;
    logic [K:0]        w_valid_ext;
    logic [DATA_W-1:0] w_score [K];
    logic [IDX_W-1:0]  w_idx   [K];
    logic [DATA_W-1:0] w_sel_score;
    logic [IDX_W-1:0]  w_sel_idx;
    logic              w_sel_last;

    assign in_ready    = (r_state_q == ST_COLLECT);
    assign w_accept    = in_valid && in_ready;
    assign w_clear     = (r_state_q == ST_IDLE) && start;
    assign w_at_last   = (r_cnt_q == c_LAST_IDX);
    assign w_valid_ext = {1'b0, w_valid};

    // First slot the new beat beats takes it; every slot below shifts down.
    always_comb begin
        w_seen = 1'b0;
        w_ins  = '0;
        w_shf  = '0;
        for (int i = 0; i < K; i++) begin
            w_ins[i] = w_beaten[i] && !w_seen;
            w_shf[i] = w_seen;
            w_seen   = w_seen || w_beaten[i];
        end
    end

    for (genvar gi = 0; gi < K; gi++) begin : g_slot
        logic              w_up_valid;
        logic [DATA_W-1:0] w_up_score;
        logic [IDX_W-1:0]  w_up_idx;

        if (gi == 0) begin : g_head
            assign w_up_valid = 1'b0;
            assign w_up_score = '0;
            assign w_up_idx   = '0;
        end else begin : g_body
            assign w_up_valid = w_valid[gi-1];
            assign w_up_score = w_score[gi-1];
            assign w_up_idx   = w_idx[gi-1];
        end

        topk_slot #(
            .DATA_W (DATA_W),
            .IDX_W  (IDX_W)
        ) u_slot (
            .clk         (CLK),
            .rst         (RESET),
            .i_clear     (w_clear),
            .i_accept    (w_accept),
            .i_ins_here  (w_ins[gi]),
            .i_shift     (w_shf[gi]),
            .i_up_valid  (w_up_valid),
            .i_up_score  (w_up_score),
            .i_up_idx    (w_up_idx),
            .i_new_score (in_data),
            .i_new_idx   (r_cnt_q),
            .o_valid     (w_valid[gi]),
            .o_score     (w_score[gi]),
            .o_idx       (w_idx[gi]),
            .o_beaten    (w_beaten[gi])
        );
    end

    always_comb begin
        w_sel_score = '0;
        w_sel_idx   = '0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (r_rank_q == 3'(i)) begin
                w_sel_score = w_score[i];
                w_sel_idx   = w_idx[i];
                w_sel_last  = !w_valid_ext[i+1];
            end
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_rank_d  = r_rank_q;
        w_err_d   = r_err_q;
        w_done_d  = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_state_d = ST_COLLECT;
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                end
            end
            ST_COLLECT: begin
                if (w_accept) begin
                    if (!w_at_last) begin
                        w_cnt_d = r_cnt_q + 1'b1;
                    end
                    if (in_last || w_at_last) begin
                        w_state_d = ST_EMIT;
                        w_rank_d  = '0;
                        if (in_last != w_at_last) begin
                            w_err_d = 1'b1;
                        end
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (w_sel_last) begin
                        w_state_d = ST_IDLE;
                        w_done_d  = 1'b1;
                    end else begin
                        w_rank_d = r_rank_q + 3'd1;
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= '0;
            r_rank_q  <= '0;
            r_err_q   <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_rank_q  <= w_rank_d;
            r_err_q   <= w_err_d;
            r_done_q  <= w_done_d;
        end
    end

    // Record fields are forced to zero outside EMIT so idle outputs stay quiet.
    assign out_valid = (r_state_q == ST_EMIT);
    assign out_rank  = out_valid ? r_rank_q    : 3'd0;
    assign out_idx   = out_valid ? w_sel_idx   : '0;
    assign out_score = out_valid ? w_sel_score : '0;
    assign out_last  = out_valid && w_sel_last;
    assign done      = r_done_q;
    assign err_len   = r_err_q;
    assign fsm_state = r_state_q;

endmodule
`default_nettype wire

// File: tb/tb_mobilenet_topk_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mobilenet_topk_classifier
//  Brief    : Directed self-checking bench for the top-K classifier.
//  Revision : 1.0
// ============================================================================
module tb_mobilenet_topk_classifier;

    localparam int DATA_W = 32;
    localparam int K      = 5;
    localparam int IDX_W  = 10;
    localparam int NCLS   = 1000;

    logic              CLK       = 1'b0;
    logic              RESET     = 1'b1;
    logic              start     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              in_last   = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] in_data   = '0;
    logic              in_ready, out_valid, out_last, done, err_len;
    logic [2:0]        out_rank;
    logic [IDX_W-1:0]  out_idx;
    logic [DATA_W-1:0] out_score;
    logic [1:0]        fsm_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DATA_W-1:0] vec [NCLS];
    int                nrec;
    logic [2:0]        rec_rank  [16];
    logic [IDX_W-1:0]  rec_idx   [16];
    logic [DATA_W-1:0] rec_score [16];
    logic              rec_last  [16];
    int                exp_n;
    int                exp_idx   [8];
    int                exp_score [8];
    bit                ok;

    mobilenet_topk_classifier #(
        .NUM_CLASSES (NCLS),
        .DATA_W      (DATA_W),
        .K           (K),
        .IDX_W       (IDX_W)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rank  (out_rank),
        .out_idx   (out_idx),
        .out_score (out_score),
        .out_last  (out_last),
        .done      (done),
        .err_len   (err_len),
        .fsm_state (fsm_state)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic stream(input int n, input int last_pos, input int start_pos);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = vec[i];
            in_last  = (i == last_pos);
            start    = (i == start_pos);
            tick;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
    endtask

    task automatic gather(output bit fin);
        fin       = 1'b0;
        nrec      = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && !fin; c++) begin
            if (out_valid && nrec < 16) begin
                rec_rank[nrec]  = out_rank;
                rec_idx[nrec]   = out_idx;
                rec_score[nrec] = out_score;
                rec_last[nrec]  = out_last;
                nrec++;
                if (out_last) fin = 1'b1;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        tick;
        tick;
        n_cmp++; if (fsm_state !== 2'd0) begin n_bad++; $display("FAIL reset_fsm: got %0d want 0", fsm_state); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b/%b want 0/0", out_valid, out_last); end
        n_cmp++; if (done !== 1'b0 || err_len !== 1'b0) begin n_bad++; $display("FAIL reset_flags: done %b err %b want 0 0", done, err_len); end
        n_cmp++; if (out_idx !== '0 || out_score !== '0 || out_rank !== 3'd0) begin n_bad++; $display("FAIL reset_record: got %0d/%0d/%0d want 0", out_rank, out_idx, out_score); end
        RESET = 1'b0;
        tick;
    endtask

    task automatic test_ramp;
        for (int i = 0; i < NCLS; i++) vec[i] = DATA_W'(i);
        exp_n = 5;
        for (int r = 0; r < 5; r++) begin exp_idx[r] = 999 - r; exp_score[r] = 999 - r; end
        do_start;
        n_cmp++; if (fsm_state !== 2'd1) begin n_bad++; $display("FAIL ramp_collect: got %0d want 1", fsm_state); end
        stream(NCLS, NCLS - 1, -1);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ramp_latency: out_valid %b want 1", out_valid); end
        gather(ok);
        n_cmp++; if (!ok || nrec != exp_n) begin n_bad++; $display("FAIL ramp_count: got %0d records (fin %b) want %0d", nrec, ok, exp_n); end
        for (int r = 0; r < nrec && r < exp_n; r++) begin
            n_cmp++;
            if (rec_rank[r] !== 3'(r) || rec_idx[r] !== IDX_W'(exp_idx[r]) || rec_score[r] !== DATA_W'(exp_score[r]) || rec_last[r] !== (r == exp_n - 1)) begin
                n_bad++;
                $display("FAIL ramp_rec%0d: got (%0d,%0d,%0d,last %b) want (%0d,%0d,%0d,last %b)", r, rec_rank[r], rec_idx[r], $signed(rec_score[r]), rec_last[r], r, exp_idx[r], exp_score[r], r == exp_n - 1);
            end
        end
        n_cmp++; if (done !== 1'b1 || fsm_state !== 2'd0) begin n_bad++; $display("FAIL ramp_done: done %b fsm %0d want 1 0", done, fsm_state); end
        n_cmp++; if (err_len !== 1'b0) begin n_bad++; $display("FAIL ramp_err: got %b want 0", err_len); end
        tick;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL ramp_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_ties;
        for (int i = 0; i < NCLS; i++) vec[i] = -32'sd7;
        vec[412] = 32'd3;
        vec[17]  = 32'd3;
        exp_n = 5;
        exp_idx   = '{17, 412, 0, 1, 2, 0, 0, 0};
        exp_score = '{3, 3, -7, -7, -7, 0, 0, 0};
        do_start;
        stream(NCLS, NCLS - 1, -1);
        gather(ok);
        n_cmp++; if (!ok || nrec != exp_n) begin n_bad++; $display("FAIL ties_count: got %0d records (fin %b) want %0d", nrec, ok, exp_n); end
        for (int r = 0; r < nrec && r < exp_n; r++) begin
            n_cmp++;
            if (rec_rank[r] !== 3'(r) || rec_idx[r] !== IDX_W'(exp_idx[r]) || rec_score[r] !== DATA_W'(exp_score[r]) || rec_last[r] !== (r == exp_n - 1)) begin
                n_bad++;
                $display("FAIL ties_rec%0d: got (%0d,%0d,%0d,last %b) want (%0d,%0d,%0d)", r, rec_rank[r], rec_idx[r], $signed(rec_score[r]), rec_last[r], r, exp_idx[r], exp_score[r]);
            end
        end
        n_cmp++; if (err_len !== 1'b0) begin n_bad++; $display("FAIL ties_err: got %b want 0", err_len); end
        tick;
    endtask

    task automatic test_short;
        vec[0] = 32'd5; vec[1] = 32'd9; vec[2] = 32'd1;
        exp_n = 3;
        exp_idx   = '{1, 0, 2, 0, 0, 0, 0, 0};
        exp_score = '{9, 5, 1, 0, 0, 0, 0, 0};
        do_start;
        stream(3, 2, -1);
        n_cmp++; if (err_len !== 1'b1) begin n_bad++; $display("FAIL short_err: got %b want 1", err_len); end
        gather(ok);
        n_cmp++; if (!ok || nrec != exp_n) begin n_bad++; $display("FAIL short_count: got %0d records (fin %b) want %0d", nrec, ok, exp_n); end
        for (int r = 0; r < nrec && r < exp_n; r++) begin
            n_cmp++;
            if (rec_rank[r] !== 3'(r) || rec_idx[r] !== IDX_W'(exp_idx[r]) || rec_score[r] !== DATA_W'(exp_score[r]) || rec_last[r] !== (r == exp_n - 1)) begin
                n_bad++;
                $display("FAIL short_rec%0d: got (%0d,%0d,%0d,last %b) want (%0d,%0d,%0d,last %b)", r, rec_rank[r], rec_idx[r], $signed(rec_score[r]), rec_last[r], r, exp_idx[r], exp_score[r], r == exp_n - 1);
            end
        end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL short_done: got %b want 1", done); end
        tick;
    endtask

    task automatic test_no_last;
        for (int i = 0; i < NCLS; i++) vec[i] = DATA_W'(1000 - i);
        exp_n = 5;
        for (int r = 0; r < 5; r++) begin exp_idx[r] = r; exp_score[r] = 1000 - r; end
        out_ready = 1'b0;
        do_start;
        stream(NCLS, -1, -1);
        in_valid = 1'b1;
        in_data  = 32'd5000;
        n_cmp++; if (in_ready !== 1'b0 || fsm_state !== 2'd2) begin n_bad++; $display("FAIL nolast_stop: in_ready %b fsm %0d want 0 2", in_ready, fsm_state); end
        n_cmp++; if (err_len !== 1'b1) begin n_bad++; $display("FAIL nolast_err: got %b want 1", err_len); end
        tick;
        in_valid = 1'b0;
        gather(ok);
        n_cmp++; if (!ok || nrec != exp_n) begin n_bad++; $display("FAIL nolast_count: got %0d records (fin %b) want %0d", nrec, ok, exp_n); end
        for (int r = 0; r < nrec && r < exp_n; r++) begin
            n_cmp++;
            if (rec_idx[r] !== IDX_W'(exp_idx[r]) || rec_score[r] !== DATA_W'(exp_score[r])) begin
                n_bad++;
                $display("FAIL nolast_rec%0d: got (%0d,%0d) want (%0d,%0d)", r, rec_idx[r], $signed(rec_score[r]), exp_idx[r], exp_score[r]);
            end
        end
        tick;
    endtask

    task automatic test_stall;
        logic              prev_stall;
        logic [2:0]        h_rank;
        logic [IDX_W-1:0]  h_idx;
        logic [DATA_W-1:0] h_score;
        bit                fin;
        vec[0] = 32'd10; vec[1] = 32'd50; vec[2] = 32'd30;
        vec[3] = 32'd70; vec[4] = 32'd20; vec[5] = 32'd60;
        exp_n = 5;
        exp_idx   = '{3, 5, 1, 2, 4, 0, 0, 0};
        exp_score = '{70, 60, 50, 30, 20, 0, 0, 0};
        out_ready = 1'b0;
        do_start;
        stream(6, 5, -1);
        prev_stall = 1'b0;
        fin = 1'b0;
        nrec = 0;
        h_rank = '0; h_idx = '0; h_score = '0;
        for (int c = 0; c < 60 && !fin; c++) begin
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            if (prev_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_rank !== h_rank || out_idx !== h_idx || out_score !== h_score) begin
                    n_bad++;
                    $display("FAIL stall_hold: got (%b,%0d,%0d,%0d) want (1,%0d,%0d,%0d)", out_valid, out_rank, out_idx, out_score, h_rank, h_idx, h_score);
                end
            end
            prev_stall = out_valid && !out_ready;
            h_rank = out_rank; h_idx = out_idx; h_score = out_score;
            if (out_valid && out_ready && nrec < 16) begin
                rec_rank[nrec] = out_rank; rec_idx[nrec] = out_idx;
                rec_score[nrec] = out_score; rec_last[nrec] = out_last;
                nrec++;
                if (out_last) fin = 1'b1;
            end
            tick;
        end
        n_cmp++; if (!fin || nrec != exp_n) begin n_bad++; $display("FAIL stall_count: got %0d records (fin %b) want %0d", nrec, fin, exp_n); end
        for (int r = 0; r < nrec && r < exp_n; r++) begin
            n_cmp++;
            if (rec_rank[r] !== 3'(r) || rec_idx[r] !== IDX_W'(exp_idx[r]) || rec_score[r] !== DATA_W'(exp_score[r]) || rec_last[r] !== (r == exp_n - 1)) begin
                n_bad++;
                $display("FAIL stall_rec%0d: got (%0d,%0d,%0d,last %b) want (%0d,%0d,%0d)", r, rec_rank[r], rec_idx[r], rec_score[r], rec_last[r], r, exp_idx[r], exp_score[r]);
            end
        end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL stall_done: got %b want 1", done); end
        tick;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < NCLS; i++) vec[i] = DATA_W'(i);
        out_ready = 1'b1;
        do_start;
        stream(500, -1, -1);
        in_valid = 1'b1;
        in_data  = vec[500];
        RESET    = 1'b1;
        tick;
        RESET    = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (fsm_state !== 2'd0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_state: fsm %0d in_ready %b out_valid %b want 0 0 0", fsm_state, in_ready, out_valid); end
        for (int c = 0; c < 3; c++) begin
            tick;
            n_cmp++; if (out_valid !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rstmid_quiet: out_valid %b done %b want 0 0", out_valid, done); end
        end
        do_start;
        stream(NCLS, NCLS - 1, 300);
        n_cmp++; if (out_valid !== 1'b1 || err_len !== 1'b0) begin n_bad++; $display("FAIL rstmid_emit: out_valid %b err %b want 1 0", out_valid, err_len); end
        gather(ok);
        n_cmp++; if (!ok || nrec != 5) begin n_bad++; $display("FAIL rstmid_count: got %0d records (fin %b) want 5", nrec, ok); end
        for (int r = 0; r < nrec && r < 5; r++) begin
            n_cmp++;
            if (rec_idx[r] !== IDX_W'(999 - r) || rec_score[r] !== DATA_W'(999 - r)) begin
                n_bad++;
                $display("FAIL rstmid_rec%0d: got (%0d,%0d) want (%0d,%0d)", r, rec_idx[r], rec_score[r], 999 - r, 999 - r);
            end
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_ramp;
        test_ties;
        test_short;
        test_no_last;
        test_stall;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
